// File: rtl/ysyx_23060208_idu_scoreboard_if.sv
// Handshake bundle between the IDU/EXU/WBU side and the register scoreboard.
// The master drives the decode and retire information; the slave is the scoreboard.
interface ysyx_23060208_idu_scoreboard_if #(
    parameter int REG_WIDTH = 5,
    parameter int NUM_WB    = 2,
    parameter int TOT_WIDTH = 8
);
    logic                          idu_valid;
    logic                          exu_allowin;
    logic [REG_WIDTH-1:0]          rs1;
    logic [REG_WIDTH-1:0]          rs2;
    logic                          rs1_used;
    logic                          rs2_used;
    logic [REG_WIDTH-1:0]          rd;
    logic                          rd_wen;
    logic                          csr_rd;
    logic                          csr_wen;
    logic [NUM_WB-1:0]             wb_valid;
    logic [NUM_WB*REG_WIDTH-1:0]   wb_rd;
    logic                          wb_csr;
    logic                          flush;
    logic                          sb_ready_go;
    logic                          issue_fire;
    logic [TOT_WIDTH-1:0]          inflight_cnt;
    logic                          err_underflow;

    modport master (
        output idu_valid, exu_allowin, rs1, rs2, rs1_used, rs2_used, rd, rd_wen,
               csr_rd, csr_wen, wb_valid, wb_rd, wb_csr, flush,
        input  sb_ready_go, issue_fire, inflight_cnt, err_underflow
    );

    modport slave (
        input  idu_valid, exu_allowin, rs1, rs2, rs1_used, rs2_used, rd, rd_wen,
               csr_rd, csr_wen, wb_valid, wb_rd, wb_csr, flush,
        output sb_ready_go, issue_fire, inflight_cnt, err_underflow
    );
endinterface

// File: rtl/ysyx_23060208_idu_scoreboard.sv
// RAW/CSR interlock beside the IDU: counts in-flight writes per GPR and a CSR busy bit,
// and drives the IDU ready_go so dependent instructions wait for retirement.
module ysyx_23060208_idu_scoreboard #(
    parameter int REG_WIDTH = 5,
    parameter int CNT_WIDTH = 2,
    parameter int NUM_WB    = 2,
    parameter int TOT_WIDTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    ysyx_23060208_idu_scoreboard_if.slave   bus
);
    localparam int NUM_REGS = 1 << REG_WIDTH;
    localparam int DW       = CNT_WIDTH + 1;
    localparam int TW       = TOT_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [TW-1:0]        TOT_MAX = {2'b00, {TOT_WIDTH{1'b1}}};

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic                 csr_busy_q, csr_busy_d;
    logic [TOT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 err_q, err_d;

    logic                 stall;
    logic                 issue;
    logic                 cnt_uf;
    logic [DW-1:0]        inc_w, dec_w, sum_w, nxt_w;
    logic [TW-1:0]        inc_tot, dec_tot, tot_w;

    // Hazard looks only at registered state, so a retire never bypasses into ready_go.
    always_comb begin
        stall = 1'b0;
        if (bus.rs1_used && bus.rs1 != '0 && cnt_q[bus.rs1] != '0)
            stall = 1'b1;
        if (bus.rs2_used && bus.rs2 != '0 && cnt_q[bus.rs2] != '0)
            stall = 1'b1;
        if (bus.rd_wen && bus.rd != '0 && cnt_q[bus.rd] == CNT_MAX)
            stall = 1'b1;
        if ((bus.csr_rd || bus.csr_wen) && csr_busy_q)
            stall = 1'b1;
    end

    assign issue = bus.idu_valid & bus.exu_allowin & ~stall;

    always_comb begin
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        cnt_uf   = 1'b0;
        inc_w    = '0;
        dec_w    = '0;
        sum_w    = '0;
        nxt_w    = '0;
        inc_tot  = '0;
        dec_tot  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_w = {{CNT_WIDTH{1'b0}}, issue & bus.rd_wen & (bus.rd == REG_WIDTH'(r))};
            dec_w = '0;
            for (int k = 0; k < NUM_WB; k++) begin
                if (bus.wb_valid[k] && bus.wb_rd[k*REG_WIDTH +: REG_WIDTH] == REG_WIDTH'(r))
                    dec_w = dec_w + DW'(1);
            end
            sum_w = {1'b0, cnt_q[r]} + inc_w;
            if (sum_w < dec_w) begin
                nxt_w  = '0;
                cnt_uf = 1'b1;
            end else begin
                nxt_w = sum_w - dec_w;
            end
            if (nxt_w > {1'b0, CNT_MAX})
                nxt_w = {1'b0, CNT_MAX};
            cnt_d[r] = nxt_w[CNT_WIDTH-1:0];
            inc_tot  = inc_tot + TW'(inc_w);
            dec_tot  = dec_tot + TW'(sum_w - nxt_w);
        end

        // Total tracks the real change of each counter, so clamped retires do not skew it.
        tot_w = {2'b00, inflight_q} + inc_tot;
        if (tot_w < dec_tot)
            tot_w = '0;
        else
            tot_w = tot_w - dec_tot;
        if (tot_w > TOT_MAX)
            tot_w = TOT_MAX;
        inflight_d = tot_w[TOT_WIDTH-1:0];

        csr_busy_d = csr_busy_q;
        if (bus.wb_csr)
            csr_busy_d = 1'b0;
        if (issue && bus.csr_wen)
            csr_busy_d = 1'b1;

        err_d = err_q | cnt_uf | (bus.wb_csr & ~csr_busy_q);

        if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_d[r] = '0;
            csr_busy_d = 1'b0;
            inflight_d = '0;
            err_d      = err_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
            csr_busy_q <= 1'b0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
            csr_busy_q <= csr_busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign bus.sb_ready_go   = ~stall;
    assign bus.issue_fire    = issue;
    assign bus.inflight_cnt  = inflight_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ysyx_23060208_idu_scoreboard.sv
// Directed scoreboard bench: each stimulus cycle queues its expected outputs,
// and a monitor on the falling edge pops and compares them.
module tb_ysyx_23060208_idu_scoreboard;

    typedef struct {
        bit       rstN;
        bit       iduValid;
        bit       exuAllowin;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       rs1Used;
        bit       rs2Used;
        bit [4:0] rd;
        bit       rdWen;
        bit       csrRd;
        bit       csrWen;
        bit [1:0] wbValid;
        bit [4:0] wbRd0;
        bit [4:0] wbRd1;
        bit       wbCsr;
        bit       flush;
    } vec_t;

    typedef struct {
        string name;
        int    stamp;
        bit    readyGo;
        bit    fire;
        int    inflight;
        bit    err;
    } exp_t;

    logic clock;
    logic reset;
    int   cycleNum;
    int   checks;
    int   errors;
    exp_t expQ[$];
    vec_t v;

    ysyx_23060208_idu_scoreboard_if #(.REG_WIDTH(5), .NUM_WB(2), .TOT_WIDTH(8)) sbIf ();

    ysyx_23060208_idu_scoreboard #(
        .REG_WIDTH(5), .CNT_WIDTH(2), .NUM_WB(2), .TOT_WIDTH(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sbIf)
    );

    // 10-time-unit clock; cycleNum stamps which cycle an expectation belongs to
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cycleNum = 0;
    always @(posedge clock) cycleNum <= cycleNum + 1;

    function automatic vec_t idle();
        vec_t t;
        t = '{default: '0};
        t.rstN = 1'b1;
        return t;
    endfunction

    function automatic vec_t issueRd(input bit [4:0] rd);
        vec_t t;
        t = idle();
        t.iduValid   = 1'b1;
        t.exuAllowin = 1'b1;
        t.rd         = rd;
        t.rdWen      = 1'b1;
        return t;
    endfunction

    // Drives one cycle of inputs just after the rising edge and queues what the
    // DUT must show on the following falling edge, then advances one cycle
    task automatic applyStimulus(input string name, input vec_t s, input bit rg,
                                 input bit fire, input int inflight, input bit err);
        exp_t e;
        reset                = s.rstN;
        sbIf.idu_valid       = s.iduValid;
        sbIf.exu_allowin     = s.exuAllowin;
        sbIf.rs1             = s.rs1;
        sbIf.rs2             = s.rs2;
        sbIf.rs1_used        = s.rs1Used;
        sbIf.rs2_used        = s.rs2Used;
        sbIf.rd              = s.rd;
        sbIf.rd_wen          = s.rdWen;
        sbIf.csr_rd          = s.csrRd;
        sbIf.csr_wen         = s.csrWen;
        sbIf.wb_valid        = s.wbValid;
        sbIf.wb_rd           = {s.wbRd1, s.wbRd0};
        sbIf.wb_csr          = s.wbCsr;
        sbIf.flush           = s.flush;
        e.name     = name;
        e.stamp    = cycleNum;
        e.readyGo  = rg;
        e.fire     = fire;
        e.inflight = inflight;
        e.err      = err;
        expQ.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Compares every observable output against one queued expectation
    task automatic checkOutput(input exp_t e);
        checks++;
        if (sbIf.sb_ready_go !== e.readyGo) begin
            errors++;
            $display("[TB] FAIL %s.readyGo got %0b want %0b", e.name, sbIf.sb_ready_go, e.readyGo);
        end
        checks++;
        if (sbIf.issue_fire !== e.fire) begin
            errors++;
            $display("[TB] FAIL %s.fire got %0b want %0b", e.name, sbIf.issue_fire, e.fire);
        end
        checks++;
        if (sbIf.inflight_cnt !== 8'(e.inflight)) begin
            errors++;
            $display("[TB] FAIL %s.inflight got %0d want %0d", e.name, sbIf.inflight_cnt, e.inflight);
        end
        checks++;
        if (sbIf.err_underflow !== e.err) begin
            errors++;
            $display("[TB] FAIL %s.err got %0b want %0b", e.name, sbIf.err_underflow, e.err);
        end
    endtask

    // Monitor: on every falling edge, consume the expectations stamped for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (expQ.size() > 0 && expQ[0].stamp <= cycleNum) begin
                e = expQ.pop_front();
                if (e.stamp < cycleNum) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s.stale got cycle %0d want cycle %0d", e.name, cycleNum, e.stamp);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    // Directed sequence; expected values are hand-derived from the register state
    // before each rising edge (counters only change on the edge)
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        v = idle();
        v.rstN = 1'b0;
        @(posedge clock);
        #1;
        applyStimulus("resetHold", v, 1, 0, 0, 0);

        applyStimulus("idle", idle(), 1, 0, 0, 0);

        applyStimulus("raw.issue5", issueRd(5), 1, 1, 0, 0);
        v = issueRd(6);
        v.rs1 = 5;
        v.rs1Used = 1;
        applyStimulus("raw.stall1", v, 0, 0, 1, 0);
        applyStimulus("raw.stall2", v, 0, 0, 1, 0);
        v.wbValid = 2'b01;
        v.wbRd0 = 5;
        applyStimulus("raw.retireNoBypass", v, 0, 0, 1, 0);
        v.wbValid = 2'b00;
        applyStimulus("raw.release", v, 1, 1, 0, 0);
        v = idle();
        v.wbValid = 2'b10;
        v.wbRd1 = 6;
        applyStimulus("raw.retire6", v, 1, 0, 1, 0);

        applyStimulus("dual.issue7a", issueRd(7), 1, 1, 0, 0);
        applyStimulus("dual.issue7b", issueRd(7), 1, 1, 1, 0);
        v = issueRd(7);
        v.wbValid = 2'b11;
        v.wbRd0 = 7;
        v.wbRd1 = 7;
        applyStimulus("dual.issueRetire2", v, 1, 1, 2, 0);
        v = idle();
        v.rs2 = 7;
        v.rs2Used = 1;
        applyStimulus("dual.rs2StallNoValid", v, 0, 0, 1, 0);
        v = idle();
        v.wbValid = 2'b01;
        v.wbRd0 = 7;
        applyStimulus("dual.retireLast", v, 1, 0, 1, 0);

        applyStimulus("sat.issue3a", issueRd(3), 1, 1, 0, 0);
        applyStimulus("sat.issue3b", issueRd(3), 1, 1, 1, 0);
        applyStimulus("sat.issue3c", issueRd(3), 1, 1, 2, 0);
        applyStimulus("sat.stall", issueRd(3), 0, 0, 3, 0);
        v = issueRd(3);
        v.wbValid = 2'b01;
        v.wbRd0 = 3;
        applyStimulus("sat.retireSameCycle", v, 0, 0, 3, 0);
        applyStimulus("sat.fireAfter", issueRd(3), 1, 1, 2, 0);

        v = issueRd(0);
        v.rs1 = 0;
        v.rs1Used = 1;
        applyStimulus("x0.issue", v, 1, 1, 3, 0);
        v = idle();
        v.wbValid = 2'b01;
        v.wbRd0 = 0;
        applyStimulus("x0.retire", v, 1, 0, 3, 0);
        v = idle();
        v.wbValid = 2'b10;
        v.wbRd1 = 9;
        applyStimulus("uf.retire9", v, 1, 0, 3, 0);
        applyStimulus("uf.set", idle(), 1, 0, 3, 1);
        applyStimulus("uf.sticky", idle(), 1, 0, 3, 1);

        v = idle();
        v.iduValid = 1;
        v.exuAllowin = 1;
        v.csrRd = 1;
        v.csrWen = 1;
        applyStimulus("csr.csrrw", v, 1, 1, 3, 1);
        v.csrWen = 0;
        applyStimulus("csr.ecallStall", v, 0, 0, 3, 1);
        v.flush = 1;
        v.wbValid = 2'b11;
        v.wbRd0 = 3;
        v.wbRd1 = 9;
        applyStimulus("csr.flushCycle", v, 0, 0, 3, 1);
        v.flush = 0;
        v.wbValid = 2'b00;
        applyStimulus("csr.ecallFires", v, 1, 1, 0, 1);

        applyStimulus("arst.issue5a", issueRd(5), 1, 1, 0, 1);
        applyStimulus("arst.issue5b", issueRd(5), 1, 1, 1, 1);
        v = idle();
        v.iduValid = 1;
        v.exuAllowin = 1;
        v.rs1 = 5;
        v.rs1Used = 1;
        applyStimulus("arst.stall", v, 0, 0, 2, 1);
        v.rstN = 0;
        applyStimulus("arst.midCycle", v, 1, 1, 0, 0);
        v.rstN = 1;
        v.exuAllowin = 0;
        applyStimulus("arst.noAllowin", v, 1, 0, 0, 0);

        v = idle();
        v.wbCsr = 1;
        applyStimulus("csrUf.retire", v, 1, 0, 0, 0);
        applyStimulus("csrUf.set", idle(), 1, 0, 0, 1);

        repeat (2) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_idu_scoreboard.md
Name: ysyx_23060208_idu_scoreboard

Overview:
- Parametrised register scoreboard that sits beside the IDU.
- Replaces the fixed idu_ready_go = 1 with a real RAW and CSR interlock.
- Counts in-flight writes per architectural register, on issue from IDU to EXU and on retirement from multiple writeback ports.
- Drives the IDU ready_go so that an instruction only leaves IDU once its sources are not pending.

Parameters:
REG_WIDTH, 5, register index width; number of tracked registers NUM_REGS = 2**REG_WIDTH; x0 is never tracked.
CNT_WIDTH, 2, per-register pending-write counter width; CNT_MAX = 2**CNT_WIDTH-1.
NUM_WB, 2, number of independent writeback ports (ALU path, LSU path).
TOT_WIDTH, 8, width of the total in-flight counter output.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low (asserted at 0); clears all state.
idu_valid  input  1  IDU holds a decoded instruction.
exu_allowin  input  1  EXU can accept this cycle.
rs1  input  REG_WIDTH  source register 1 index.
rs2  input  REG_WIDTH  source register 2 index.
rs1_used  input  1  instruction reads rs1.
rs2_used  input  1  instruction reads rs2.
rd  input  REG_WIDTH  destination index.
rd_wen  input  1  instruction writes rd.
csr_rd  input  1  instruction reads a CSR (csrrw/csrrs/ecall/mret).
csr_wen  input  1  instruction writes a CSR.
wb_valid  input  NUM_WB  per-port retire strobe.
wb_rd  input  NUM_WB*REG_WIDTH  packed retire indices; port k at [k*REG_WIDTH +: REG_WIDTH].
wb_csr  input  1  a CSR write retires this cycle.
flush  input  1  synchronous squash of all in-flight tracking.
sb_ready_go  output  1  IDU ready_go; 1 = no hazard.
issue_fire  output  1  idu_valid & exu_allowin & sb_ready_go.
inflight_cnt  output  TOT_WIDTH  total pending GPR writes.
err_underflow  output  1  sticky: retire seen for a register whose count is 0.

Behaviour:
- Reset (reset==0, async):
  - all counters = 0, csr_busy = 0, inflight_cnt = 0, err_underflow = 0.
  - Consequently sb_ready_go = 1 and issue_fire = 0 unless idu_valid & exu_allowin.
- Hazard (combinational, same cycle): sb_stall = any of
  - rs1_used & rs1!=0 & cnt[rs1]!=0
  - rs2_used & rs2!=0 & cnt[rs2]!=0
  - rd_wen & rd!=0 & cnt[rd]==CNT_MAX (saturation stall)
  - (csr_rd | csr_wen) & csr_busy
- sb_ready_go = ~sb_stall. It is independent of idu_valid, so there is no combinational loop through exu_allowin.
- Update each rising edge, with flush having the highest priority:
  - flush=1: all counters = 0, csr_busy = 0, inflight_cnt = 0. Issue and retire in the same cycle are ignored. err_underflow is held.
  - Otherwise, for each register r != 0: cnt[r] += inc - dec.
    - inc = issue_fire & rd_wen & rd==r.
    - dec = number of ports k with wb_valid[k] & wb_rd[k]==r (0..NUM_WB).
    - Net arithmetic is at CNT_WIDTH+1 bits.
    - If inc - dec would go below 0, cnt becomes 0 and err_underflow is set (sticky until reset).
  - Issue and retire of the same register in the same cycle cancel out (no change).
  - Writes to x0 (issue or retire) are ignored entirely and never cause underflow.
  - csr_busy: set on issue_fire & csr_wen, cleared on wb_csr. If both happen in one cycle, the result is 1, because the new issue is younger. wb_csr while csr_busy==0 sets err_underflow.
  - inflight_cnt = sum of all counters, maintained incrementally. It saturates at 2**TOT_WIDTH-1 and never wraps.
- Latency:
  - A retire in cycle N clears the hazard in cycle N+1; there is no same-cycle bypass of wb to sb_ready_go.
  - An issue in cycle N makes a dependent instruction stall from cycle N+1.
- Stall is independent of exu_allowin. While stalled, IDU holds its payload (idu_allowin falls via ready_go), and no counter changes from the issue side.

Test Plan:
- Reset then idle: release reset with idu_valid=0 -> sb_ready_go=1, inflight_cnt=0, err_underflow=0. Assert reset mid-run with cnt[5]=2 -> immediately cnt[5]=0 and sb_ready_go=1 for rs1=5.
- RAW stall: issue rd=5 (cycle 0); next instruction rs1=5, rs1_used=1 -> sb_ready_go=0 and issue_fire=0 until wb_valid[0] with wb_rd=5 in cycle 3 -> sb_ready_go=1 in cycle 4, inflight_cnt goes 1 -> 0.
- Dual retire plus simultaneous issue: cnt[7]=2; in one cycle issue rd=7 and retire 7 on both ports -> cnt[7]=1, inflight_cnt=1.
- Saturation: with CNT_WIDTH=2, issue rd=3 three times without retire -> a fourth rd=3 writer gets sb_ready_go=0; one retire of 3 -> it fires next cycle.
- x0 and underflow: issue rd=0, rs1=0 -> no stall, inflight_cnt unchanged. Retire wb_rd=9 with cnt[9]=0 -> err_underflow=1 and stays 1.
- Flush and CSR: csrrw issued (csr_busy=1), then ecall with csr_rd=1 stalls; flush=1 together with wb_valid -> all counters and csr_busy are 0 next cycle, ecall fires, and err_underflow is unchanged.
